// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: packs a UART byte stream MSB-first into words,
// writes them to consecutive word addresses from 0 and releases the CPU from
// reset once the HALT word has been stored.
//
// Handshake: i_rx_valid is a one-cycle strobe with no back-pressure; every
// strobe seen while receiving is consumed on that clock edge. o_inst_mem_wr_en
// is a one-cycle strobe; o_inst_mem_addr/o_inst_mem_data are meaningful only
// while it is high and otherwise hold their last written values.
module inst_mem_loader #(
  parameter int          NBITS     = 32,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_load_start,
  output logic              o_inst_mem_wr_en,
  output logic [NBITS-1:0]  o_inst_mem_addr,
  output logic [NBITS-1:0]  o_inst_mem_data,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_word_count,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [NBITS-9:0]  sh_q, sh_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [NBITS-1:0]  addr_q, addr_d;
  logic [NBITS-1:0]  data_q, data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [NBITS-1:0]  word;
  logic [ADDR_W:0]   word_cnt_inc;

  // Next-state logic: a load start from any state restarts the load and wins
  // over a coincident byte; the 4th byte of a word produces the write.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    sh_d         = sh_q;
    word_cnt_d   = word_cnt_q;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    err_d        = err_q;
    word         = {sh_q, i_rx_data};
    word_cnt_inc = (word_cnt_q == DEPTH) ? word_cnt_q : word_cnt_q + ONE;

    if (i_load_start) begin
      state_d    = S_RECV;
      byte_cnt_d = 2'd0;
      sh_d       = '0;
      word_cnt_d = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cpu_rst_d  = 1'b1;
    end else if (state_q == S_RECV && i_rx_valid) begin
      sh_d       = word[NBITS-9:0];
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        wr_en_d    = 1'b1;
        data_d     = word;
        addr_d     = NBITS'({word_cnt_q[ADDR_W-1:0], 2'b00});
        word_cnt_d = word_cnt_inc;
        if (word == HALT_WORD[NBITS-1:0]) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else if (word_cnt_inc == DEPTH) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
    end
  end

  // State and registered outputs; synchronous reset returns everything to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      sh_q       <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_inst_mem_wr_en = wr_en_q;
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = data_q;
  assign o_cpu_rst        = cpu_rst_q;
  assign o_load_done      = done_q;
  assign o_load_err       = err_q;
  assign o_word_count     = word_cnt_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Testbench for inst_mem_loader with a small memory (4 words) so overflow is
// reachable. A byte-queue model predicts every registered output each cycle.
module tb_inst_mem_loader;

  localparam int          NBITS = 32;
  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;
  localparam int          M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             load_start;
  logic             wr_en;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] data;
  logic             cpu_rst;
  logic             load_done;
  logic             load_err;
  logic [AW:0]      word_count;
  logic [1:0]       dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_mem_loader #(.NBITS(NBITS), .ADDR_W(AW), .HALT_WORD(HALT)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_load_start(load_start), .o_inst_mem_wr_en(wr_en), .o_inst_mem_addr(addr),
    .o_inst_mem_data(data), .o_cpu_rst(cpu_rst), .o_load_done(load_done),
    .o_load_err(load_err), .o_word_count(word_count), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // behavioural model: bytes collect in a queue; four bytes make a word
  logic [7:0]  bq[$];
  logic [63:0] exp_q[$];
  logic [63:0] wr_log[$];
  int          m_mode = M_IDLE;
  int          m_cnt = 0;
  logic        m_wr = 0, m_cpu = 0, m_done = 0, m_err = 0;
  logic [31:0] m_addr, m_word;
  bit          armed = 0;

  always @(posedge clk) begin
    m_wr = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; bq.delete(); m_cnt = 0;
      m_cpu = 0; m_done = 0; m_err = 0;
    end else if (load_start) begin
      m_mode = M_LOAD; bq.delete(); m_cnt = 0;
      m_cpu = 1; m_done = 0; m_err = 0;
    end else if (m_mode == M_LOAD && rx_valid) begin
      bq.push_back(rx_data);
      if (bq.size() == 4) begin
        m_word = {bq[0], bq[1], bq[2], bq[3]};
        bq.delete();
        m_wr = 1'b1;
        m_addr = 32'(m_cnt * 4);
        exp_q.push_back({m_addr, m_word});
        m_cnt++;
        if (m_word == HALT) begin
          m_mode = M_DONE; m_done = 1; m_cpu = 0;
        end else if (m_cnt == DEPTH) begin
          m_mode = M_ERR; m_err = 1;
        end
      end
    end
    armed = 1;
  end

  // compare process: every output, every cycle, sampled on the falling edge
  logic [63:0] exp_w;
  always @(negedge clk) begin
    if (armed) begin
      chk("wr_en", 64'(wr_en), 64'(m_wr));
      if (wr_en) begin
        wr_log.push_back({addr, data});
        if (exp_q.size() == 0) chk("unexpected_write", {addr, data}, 64'h0);
        else begin
          exp_w = exp_q.pop_front();
          chk("wr_addr", 64'(addr), 64'(exp_w[63:32]));
          chk("wr_data", 64'(data), 64'(exp_w[31:0]));
        end
      end
      chk("cpu_rst", 64'(cpu_rst), 64'(m_cpu));
      chk("load_done", 64'(load_done), 64'(m_done));
      chk("load_err", 64'(load_err), 64'(m_err));
      chk("word_count", 64'(word_count), 64'(m_cnt));
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    rst = 1'b1; rx_data = 8'h0; rx_valid = 1'b0; load_start = 1'b0;
    idle(3);
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_addr", 64'(addr), 64'h0);
    chk("rst_data", 64'(data), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    rst = 1'b0;
    idle(1);

    // basic program
    wr_log.delete();
    pulse_start();
    chk("t1_cpu_rst_loading", 64'(cpu_rst), 64'h1);
    send_word(32'h20080005, 1'b1);
    send_word(32'hFFFFFFFF, 1'b1);
    idle(2);
    chk("t1_nwrites", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      chk("t1_w0", wr_log[0], {32'h0, 32'h20080005});
      chk("t1_w1", wr_log[1], {32'h4, 32'hFFFFFFFF});
    end
    chk("t1_done", 64'(load_done), 64'h1);
    chk("t1_cpu_rst", 64'(cpu_rst), 64'h0);
    chk("t1_count", 64'(word_count), 64'd2);
    chk("t1_model_count", 64'(m_cnt), 64'd2);

    // back-to-back strobes, 12 consecutive bytes
    wr_log.delete();
    pulse_start();
    send_word(32'hA1B2C3D4, 1'b0);
    send_word(32'h01020304, 1'b0);
    send_word(HALT, 1'b0);
    idle(2);
    chk("t2_nwrites", 64'(wr_log.size()), 64'd3);
    if (wr_log.size() == 3) begin
      chk("t2_w0", wr_log[0], {32'h0, 32'hA1B2C3D4});
      chk("t2_w1", wr_log[1], {32'h4, 32'h01020304});
      chk("t2_w2", wr_log[2], {32'h8, 32'hFFFFFFFF});
    end

    // HALT on the last address wins over overflow
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(rnd_word(), 1'b0);
    send_word(HALT, 1'b0);
    idle(2);
    chk("t3_halt_last_done", 64'(load_done), 64'h1);
    chk("t3_halt_last_err", 64'(load_err), 64'h0);
    chk("t3_halt_last_count", 64'(word_count), 64'd4);

    // overflow
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(rnd_word(), 1'b0);
    idle(2);
    chk("t3_err", 64'(load_err), 64'h1);
    chk("t3_cpu_rst", 64'(cpu_rst), 64'h1);
    chk("t3_count_sat", 64'(word_count), 64'd4);
    send_word(rnd_word(), 1'b0);
    send_word(HALT, 1'b0);
    idle(2);
    chk("t3_nwrites", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) chk("t3_last_addr", 64'(wr_log[3][63:32]), 64'd12);

    // restart mid-word
    wr_log.delete();
    pulse_start();
    send_byte(8'h55); send_byte(8'h66);
    pulse_start();
    send_word(32'h11223344, 1'b1);
    idle(2);
    chk("t4_nwrites", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) chk("t4_w0", wr_log[0], {32'h0, 32'h11223344});

    // restart coinciding with a 4th-byte strobe
    wr_log.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    load_start = 1'b1; rx_data = 8'h04; rx_valid = 1'b1;
    @(negedge clk);
    load_start = 1'b0; rx_valid = 1'b0;
    send_word(32'hAABBCCDD, 1'b0);
    idle(2);
    chk("t4c_nwrites", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) chk("t4c_w0", wr_log[0], {32'h0, 32'hAABBCCDD});

    // reset mid-load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(i + 8'h30));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wr_log.delete();
    chk("t5_wr_en", 64'(wr_en), 64'h0);
    chk("t5_cpu_rst", 64'(cpu_rst), 64'h0);
    chk("t5_count", 64'(word_count), 64'h0);
    chk("t5_state", 64'(dbg_state), 64'h0);
    chk("t5_addr", 64'(addr), 64'h0);
    send_word(rnd_word(), 1'b0);
    send_word(HALT, 1'b0);
    idle(2);
    chk("t5_nwrites", 64'(wr_log.size()), 64'd0);

    // reload after DONE
    pulse_start();
    send_word(32'hDEADBEEF, 1'b0);
    send_word(HALT, 1'b0);
    idle(1);
    chk("t6_done_first", 64'(load_done), 64'h1);
    wr_log.delete();
    pulse_start();
    chk("t6_done_drop", 64'(load_done), 64'h0);
    chk("t6_cpu_rst", 64'(cpu_rst), 64'h1);
    chk("t6_count_clr", 64'(word_count), 64'h0);
    send_word(32'h12345678, 1'b1);
    send_word(HALT, 1'b1);
    idle(2);
    if (wr_log.size() > 0) chk("t6_w0", wr_log[0], {32'h0, 32'h12345678});
    else chk("t6_nwrites", 64'(wr_log.size()), 64'd2);
    chk("t6_done_again", 64'(load_done), 64'h1);

    // randomized programs with occasional restarts and resets
    for (int it = 0; it < 30; it++) begin
      pulse_start();
      for (int w = 0; w < $urandom_range(1, 5); w++) begin
        if ($urandom_range(0, 3) == 0) send_word(HALT, $urandom_range(0, 1) == 1);
        else send_word(rnd_word(), $urandom_range(0, 1) == 1);
        case ($urandom_range(0, 15))
          0: pulse_start();
          1: begin rst = 1'b1; idle(1); rst = 1'b0; end
          2: begin load_start = 1'b1; send_byte(8'($urandom)); load_start = 1'b0; end
          default: ;
        endcase
      end
      idle($urandom_range(1, 3));
    end

    idle(2);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
